// File: rtl/pwr_meas_sequencer.sv
// Measurement sequencer for adder power analysis: clears the transition-counter memory,
// drives a reproducible LFSR operand stream, then streams every counter value out.
module pwr_meas_sequencer #(
    parameter int          NUM_CNTR = 3,
    parameter int          NDIR     = 2,
    parameter int          NUM_SUMS = 100,
    parameter int          HOLD     = 4,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic            clk,
    input  logic            reset_L,
    input  logic            start,
    output logic [7:0]      oprA,
    output logic [7:0]      oprB,
    output logic [31:0]     sum_cnt,
    output logic [NDIR-1:0] dir,
    output logic            LE,
    output logic [31:0]     dato_out,
    output logic            dato_oe,
    input  logic [31:0]     dato_in,
    output logic            rd_valid,
    output logic [NDIR-1:0] rd_dir,
    output logic [31:0]     rd_data,
    input  logic            rd_ready,
    output logic            busy,
    output logic            done
);

    localparam int              HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD - 1);
    localparam logic [NDIR-1:0] DIR_LAST  = NDIR'(NUM_CNTR - 1);
    localparam logic [31:0]     SUM_LAST  = 32'(NUM_SUMS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_FETCH  = 3'd4,
        S_READ   = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_e          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [HCW-1:0]  hold_q, hold_d;
    logic [7:0]      opra_q, opra_d;
    logic [7:0]      oprb_q, oprb_d;
    logic [31:0]     sum_cnt_q, sum_cnt_d;
    logic [NDIR-1:0] dir_q, dir_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic [NDIR-1:0] rd_dir_q, rd_dir_d;
    logic            le_q, le_d;
    logic            dato_oe_q, dato_oe_d;
    logic            rd_valid_q, rd_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            hold_last;
    logic            sum_last;
    logic            dir_last;
    logic [15:0]     lfsr_nxt;

    assign hold_last = (hold_q == HOLD_LAST);
    assign sum_last  = (sum_cnt_q == SUM_LAST);
    assign dir_last  = (dir_q == DIR_LAST);
    assign lfsr_nxt  = lfsr_step(lfsr_q);

    // FSM state register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start only matters when not busy
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_CLEAR;
                else       state_d = state_q;
            end
            S_CLEAR: begin
                if (dir_last) state_d = S_RUN;
                else          state_d = S_CLEAR;
            end
            S_RUN: begin
                if (hold_last && sum_last) state_d = S_SETTLE;
                else                       state_d = S_RUN;
            end
            S_SETTLE: begin
                if (hold_last) state_d = S_FETCH;
                else           state_d = S_SETTLE;
            end
            S_FETCH: state_d = S_READ;
            S_READ: begin
                if (rd_ready) begin
                    if (dir_last) state_d = S_DONE;
                    else          state_d = S_FETCH;
                end else begin
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: address walk, hold timing, operand stream, readout capture
    always_comb begin
        lfsr_d    = lfsr_q;
        hold_d    = hold_q;
        opra_d    = opra_q;
        oprb_d    = oprb_q;
        sum_cnt_d = sum_cnt_q;
        dir_d     = dir_q;
        rd_data_d = rd_data_q;
        rd_dir_d  = rd_dir_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dir_d  = {NDIR{1'b0}};
                    hold_d = {HCW{1'b0}};
                end else begin
                    dir_d  = dir_q;
                end
            end
            S_CLEAR: begin
                // The stream restarts from SEED on every run so measurements are repeatable
                if (dir_last) begin
                    dir_d     = {NDIR{1'b0}};
                    lfsr_d    = SEED;
                    opra_d    = SEED[15:8];
                    oprb_d    = SEED[7:0];
                    sum_cnt_d = 32'd0;
                    hold_d    = {HCW{1'b0}};
                end else begin
                    dir_d     = dir_q + NDIR'(1);
                end
            end
            S_RUN: begin
                if (hold_last) begin
                    hold_d = {HCW{1'b0}};
                    if (!sum_last) begin
                        lfsr_d    = lfsr_nxt;
                        opra_d    = lfsr_nxt[15:8];
                        oprb_d    = lfsr_nxt[7:0];
                        sum_cnt_d = sum_cnt_q + 32'd1;
                    end else begin
                        lfsr_d    = lfsr_q;
                    end
                end else begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            S_SETTLE: begin
                dir_d = {NDIR{1'b0}};
                if (hold_last) hold_d = {HCW{1'b0}};
                else           hold_d = hold_q + HCW'(1);
            end
            S_FETCH: begin
                rd_data_d = dato_in;
                rd_dir_d  = dir_q;
            end
            S_READ: begin
                if (rd_ready && !dir_last) dir_d = dir_q + NDIR'(1);
                else                       dir_d = dir_q;
            end
            default: dir_d = dir_q;
        endcase
    end

    // FSM outputs, decoded from the next state so they come straight out of flops
    always_comb begin
        le_d       = 1'b1;
        dato_oe_d  = 1'b0;
        rd_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_d)
            S_CLEAR: begin
                le_d      = 1'b0;
                dato_oe_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_RUN, S_SETTLE, S_FETCH: busy_d = 1'b1;
            S_READ: begin
                busy_d     = 1'b1;
                rd_valid_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: le_d   = 1'b1;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            lfsr_q     <= SEED;
            hold_q     <= {HCW{1'b0}};
            opra_q     <= 8'd0;
            oprb_q     <= 8'd0;
            sum_cnt_q  <= 32'd0;
            dir_q      <= {NDIR{1'b0}};
            rd_data_q  <= 32'd0;
            rd_dir_q   <= {NDIR{1'b0}};
            le_q       <= 1'b1;
            dato_oe_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            hold_q     <= hold_d;
            opra_q     <= opra_d;
            oprb_q     <= oprb_d;
            sum_cnt_q  <= sum_cnt_d;
            dir_q      <= dir_d;
            rd_data_q  <= rd_data_d;
            rd_dir_q   <= rd_dir_d;
            le_q       <= le_d;
            dato_oe_q  <= dato_oe_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Clearing always writes zero; the bus is only driven while dato_oe is high
    assign dato_out = 32'd0;
    assign oprA     = opra_q;
    assign oprB     = oprb_q;
    assign sum_cnt  = sum_cnt_q;
    assign dir      = dir_q;
    assign LE       = le_q;
    assign dato_oe  = dato_oe_q;
    assign rd_valid = rd_valid_q;
    assign rd_dir   = rd_dir_q;
    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
